// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address and
// registers the returned word into a one-entry IF/ID stage with redirect and halt support.
module instr_fetch_unit #(
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     IMEM_WORDS = 15,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc_out,
  input  logic [15:0]     instr_in,
  output logic [15:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic            redirect_jump,
  input  logic [PC_W-1:0] redirect_src_pc,
  input  logic [11:0]     redirect_imm,
  input  logic            halt_req,
  input  logic            resume,
  output logic            fetch_fault,
  output logic            halted
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(2 * (IMEM_WORDS - 1));
  localparam logic [PC_W-1:0] WORDS   = PC_W'(IMEM_WORDS);

  state_t          state, state_n;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] seq_next, br_sum, target, new_pc;
  logic            advance, load_pc, out_of_range;

  always_comb begin
    advance  = (state == RUN) && (!if_valid || id_ready) && !redirect_valid;
    seq_next = (pc == LAST_PC) ? RESET_PC : pc + PC_W'(2);
    br_sum   = redirect_src_pc + PC_W'(2)
             + {{(PC_W-7){redirect_imm[5]}}, redirect_imm[5:0], 1'b0};
    if (redirect_jump)
      target = {redirect_src_pc[PC_W-1:13], redirect_imm, 1'b0};
    else
      target = br_sum & ~PC_W'(1);
    load_pc      = redirect_valid || advance;
    new_pc       = redirect_valid ? target : seq_next;
    // Range test is on the word index of the address about to be loaded.
    out_of_range = {1'b0, new_pc[PC_W-1:1]} >= WORDS;
  end

  always_comb begin
    state_n = state;
    if (load_pc && out_of_range)
      state_n = HALT;
    else if (redirect_valid)
      state_n = RUN;
    else if (state == RUN && halt_req)
      state_n = HALT;
    else if (state == HALT && resume && !halt_req && !fetch_fault)
      state_n = RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_n;
      if (load_pc) pc <= new_pc;
      if (load_pc && out_of_range) fetch_fault <= 1'b1;
      if (redirect_valid) begin
        if_valid <= 1'b0;
      end else if (advance) begin
        if_instr <= instr_in;
        if_pc    <= pc;
        if_valid <= 1'b1;
      end else if (if_valid && id_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

  assign pc_out = pc;
  assign halted = (state == HALT);

endmodule
